// File: rtl/i2c_write_sequencer_if.sv
// Host-side handshake and I2C pad signals of the write sequencer.
// The master modport is the sequencer's view; the slave modport is the host/pad side.
interface i2c_write_sequencer_if;
    logic        i_start;
    logic [15:0] i_data;
    logic        i_sda;
    logic        o_busy;
    logic        o_done;
    logic        o_ack_err;
    logic [15:0] o_data;
    logic        o_scl;
    logic        o_sda;
    logic        o_scl_en;
    logic        o_sda_en;

    modport master (
        input  i_start, i_data, i_sda,
        output o_busy, o_done, o_ack_err, o_data, o_scl, o_sda, o_scl_en, o_sda_en
    );

    modport slave (
        output i_start, i_data, i_sda,
        input  o_busy, o_done, o_ack_err, o_data, o_scl, o_sda, o_scl_en, o_sda_en
    );
endinterface

// File: rtl/i2c_write_sequencer.sv
// Single-master I2C write sequencer: START, {ADDR,W}, two data bytes with ACK checks, STOP.
// Optional feature macro I2C_SEQ_RETRY_EN: up to 3 attempts on an address NACK.
module i2c_write_sequencer #(
    parameter int         CLK_DIV = 4,
    parameter logic [6:0] ADDR    = 7'h50
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    i2c_write_sequencer_if.master bus
);

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_START   = 4'd1;
    localparam logic [3:0] ST_ADDR    = 4'd2;
    localparam logic [3:0] ST_ACK_A   = 4'd3;
    localparam logic [3:0] ST_BYTE_HI = 4'd4;
    localparam logic [3:0] ST_ACK_H   = 4'd5;
    localparam logic [3:0] ST_BYTE_LO = 4'd6;
    localparam logic [3:0] ST_ACK_L   = 4'd7;
    localparam logic [3:0] ST_STOP    = 4'd8;
    localparam logic [3:0] ST_DONE    = 4'd9;

    localparam logic [7:0] QMAX      = 8'(CLK_DIV - 1);
    localparam logic [7:0] ADDR_BYTE = {ADDR, 1'b0};

    logic [3:0]  state_q, state_d;
    logic [7:0]  qcnt_q, qcnt_d;
    logic [1:0]  phase_q, phase_d;
    logic [2:0]  bit_q, bit_d;
    logic        nack_q, nack_d;
    logic        ack_err_q, ack_err_d;
    logic [15:0] data_q, data_d;
`ifdef I2C_SEQ_RETRY_EN
    logic [1:0]  attempt_q, attempt_d;
    logic        retry_q, retry_d;
`endif

    logic quarter_end;
    logic slot_end;
    logic sample_pt;
    logic [7:0] tx_byte;

    assign quarter_end = (qcnt_q == QMAX);
    assign slot_end    = quarter_end && (phase_q == 2'd3);
    assign sample_pt   = (phase_q == 2'd2) && (qcnt_q == 8'd0);

    always_comb begin
        state_d   = state_q;
        qcnt_d    = qcnt_q;
        phase_d   = phase_q;
        bit_d     = bit_q;
        nack_d    = nack_q;
        ack_err_d = ack_err_q;
        data_d    = data_q;
`ifdef I2C_SEQ_RETRY_EN
        attempt_d = attempt_q;
        retry_d   = retry_q;
`endif

        // Quarter/phase timebase runs only inside a transaction.
        if ((state_q != ST_IDLE) && (state_q != ST_DONE)) begin
            qcnt_d = quarter_end ? 8'd0 : qcnt_q + 8'd1;
            if (quarter_end) begin
                phase_d = phase_q + 2'd1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.i_start) begin
                    state_d   = ST_START;
                    data_d    = bus.i_data;
                    ack_err_d = 1'b0;
                    nack_d    = 1'b0;
                    qcnt_d    = 8'd0;
                    phase_d   = 2'd0;
                    bit_d     = 3'd0;
`ifdef I2C_SEQ_RETRY_EN
                    attempt_d = 2'd0;
                    retry_d   = 1'b0;
`endif
                end
            end
            ST_START: begin
                if (slot_end) begin
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR, ST_BYTE_HI, ST_BYTE_LO: begin
                if (slot_end) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        case (state_q)
                            ST_ADDR:    state_d = ST_ACK_A;
                            ST_BYTE_HI: state_d = ST_ACK_H;
                            default:    state_d = ST_ACK_L;
                        endcase
                    end
                end
            end
            ST_ACK_A: begin
                if (sample_pt) begin
                    nack_d = bus.i_sda;
`ifdef I2C_SEQ_RETRY_EN
                    // Only the final attempt's NACK is reported.
                    if (bus.i_sda && (attempt_q == 2'd2)) begin
                        ack_err_d = 1'b1;
                    end
`else
                    if (bus.i_sda) begin
                        ack_err_d = 1'b1;
                    end
`endif
                end
                if (slot_end) begin
                    if (nack_q) begin
                        state_d = ST_STOP;
`ifdef I2C_SEQ_RETRY_EN
                        retry_d = (attempt_q != 2'd2);
`endif
                    end else begin
                        state_d = ST_BYTE_HI;
                    end
                end
            end
            ST_ACK_H, ST_ACK_L: begin
                if (sample_pt) begin
                    nack_d = bus.i_sda;
                    if (bus.i_sda) begin
                        ack_err_d = 1'b1;
                    end
                end
                if (slot_end) begin
                    if (nack_q || (state_q == ST_ACK_L)) begin
                        state_d = ST_STOP;
                    end else begin
                        state_d = ST_BYTE_LO;
                    end
                end
            end
            ST_STOP: begin
                if (slot_end) begin
`ifdef I2C_SEQ_RETRY_EN
                    if (retry_q) begin
                        state_d   = ST_START;
                        attempt_d = attempt_q + 2'd1;
                        retry_d   = 1'b0;
                    end else begin
                        state_d = ST_DONE;
                    end
`else
                    state_d = ST_DONE;
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            qcnt_q    <= 8'd0;
            phase_q   <= 2'd0;
            bit_q     <= 3'd0;
            nack_q    <= 1'b0;
            ack_err_q <= 1'b0;
            data_q    <= 16'd0;
`ifdef I2C_SEQ_RETRY_EN
            attempt_q <= 2'd0;
            retry_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            qcnt_q    <= qcnt_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            nack_q    <= nack_d;
            ack_err_q <= ack_err_d;
            data_q    <= data_d;
`ifdef I2C_SEQ_RETRY_EN
            attempt_q <= attempt_d;
            retry_q   <= retry_d;
`endif
        end
    end

    // Pad drive is decoded straight from state so reset releases the bus immediately.
    always_comb begin
        bus.o_scl    = 1'b1;
        bus.o_sda    = 1'b1;
        bus.o_scl_en = 1'b0;
        bus.o_sda_en = 1'b0;
        tx_byte      = ADDR_BYTE;
        case (state_q)
            ST_START: begin
                bus.o_scl_en = 1'b1;
                bus.o_sda_en = 1'b1;
                bus.o_sda    = ~phase_q[1];
            end
            ST_ADDR, ST_BYTE_HI, ST_BYTE_LO: begin
                if (state_q == ST_BYTE_HI) begin
                    tx_byte = data_q[15:8];
                end else if (state_q == ST_BYTE_LO) begin
                    tx_byte = data_q[7:0];
                end
                bus.o_scl_en = 1'b1;
                bus.o_sda_en = 1'b1;
                bus.o_scl    = phase_q[1];
                bus.o_sda    = tx_byte[3'd7 - bit_q];
            end
            ST_ACK_A, ST_ACK_H, ST_ACK_L: begin
                bus.o_scl_en = 1'b1;
                bus.o_scl    = phase_q[1];
            end
            ST_STOP: begin
                bus.o_scl_en = 1'b1;
                bus.o_sda_en = 1'b1;
                bus.o_scl    = phase_q[1];
                bus.o_sda    = (phase_q == 2'd3);
            end
            default: begin
            end
        endcase
    end

    assign bus.o_busy    = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign bus.o_done    = (state_q == ST_DONE);
    assign bus.o_ack_err = ack_err_q;
    assign bus.o_data    = data_q;

endmodule

// File: tb/tb_i2c_write_sequencer.sv
// Directed bench for i2c_write_sequencer: vector table on a CLK_DIV=1 instance,
// plus lockout, back-to-back, reset and CLK_DIV=3 sequences.
module tb_i2c_write_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    i2c_write_sequencer_if bus1();
    i2c_write_sequencer_if bus3();

    i2c_write_sequencer #(.CLK_DIV(1), .ADDR(7'h50)) dut1 (.i_clk(clk), .i_rst(rst), .bus(bus1));
    i2c_write_sequencer #(.CLK_DIV(3), .ADDR(7'h50)) dut3 (.i_clk(clk), .i_rst(rst), .bus(bus3));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bus monitor / ACK responder for the CLK_DIV=1 instance.
    logic        clr = 1'b0;
    logic [7:0]  mask_cur = 8'd0;
    logic [63:0] mon_bits = 64'd0;
    int          mon_nbits = 0;
    int          mon_acks = 0;
    logic [2:0]  ack_cnt = 3'd0;
    logic        cur_nack = 1'b0;
    logic        prev_scl = 1'b1;
    logic        prev_en = 1'b0;

    always @(negedge clk) begin
        if (clr) begin
            mon_bits  <= 64'd0;
            mon_nbits <= 0;
            mon_acks  <= 0;
            ack_cnt   <= 3'd0;
            cur_nack  <= 1'b0;
            prev_scl  <= 1'b1;
            prev_en   <= 1'b0;
        end else begin
            if (bus1.o_scl && !prev_scl) begin
                if (bus1.o_sda_en) begin
                    mon_bits  <= {mon_bits[62:0], bus1.o_sda};
                    mon_nbits <= mon_nbits + 1;
                end else begin
                    mon_acks <= mon_acks + 1;
                end
            end
            if (!bus1.o_sda_en && prev_en && bus1.o_busy) begin
                cur_nack <= mask_cur[ack_cnt];
                ack_cnt  <= ack_cnt + 3'd1;
            end
            prev_scl <= bus1.o_scl;
            prev_en  <= bus1.o_sda_en;
        end
    end

    assign bus1.i_sda = cur_nack & ~bus1.o_sda_en & bus1.o_busy;
    assign bus3.i_sda = 1'b0;

    typedef struct {
        logic [15:0] data;
        logic [7:0]  mask;
        int          inj;
        int          exp_done;
        int          exp_err_at;
        logic        exp_err;
        int          exp_nbits;
        logic [63:0] exp_bits;
        int          exp_acks;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs[NV];

    task automatic set_vec(input int i, input logic [15:0] d, input logic [7:0] m, input int inj,
                           input int dn, input int ea, input logic e, input int nb,
                           input logic [63:0] b, input int na);
        vecs[i].data = d; vecs[i].mask = m; vecs[i].inj = inj; vecs[i].exp_done = dn;
        vecs[i].exp_err_at = ea; vecs[i].exp_err = e; vecs[i].exp_nbits = nb;
        vecs[i].exp_bits = b; vecs[i].exp_acks = na;
    endtask

    task automatic run_txn(input logic [15:0] data, input logic [7:0] mask, input int inj,
                           output int done_at, output int err_at, output int ndone,
                           output logic [4:0] done_snap);
        done_at = -1; err_at = -1; ndone = 0; done_snap = 5'd0;
        @(posedge clk); #1;
        clr = 1'b1; mask_cur = mask; bus1.i_data = data; bus1.i_start = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0; bus1.i_start = 1'b0;
        chk("accept_flags", {58'd0, bus1.o_busy, bus1.o_scl_en, bus1.o_sda_en, bus1.o_scl,
                             bus1.o_sda, bus1.o_ack_err}, 64'b111110);
        chk("accept_data", {48'd0, bus1.o_data}, {48'd0, data});
        for (int n = 1; n <= 1000; n++) begin
            @(posedge clk); #1;
            if (n == inj) begin
                bus1.i_start = 1'b1; bus1.i_data = 16'h1234;
            end else begin
                bus1.i_start = 1'b0;
            end
            if (bus1.o_ack_err && err_at < 0) err_at = n;
            if (bus1.o_done) begin
                ndone++;
                if (done_at < 0) begin
                    done_at = n;
                    done_snap = {bus1.o_busy, bus1.o_scl, bus1.o_sda, bus1.o_scl_en, bus1.o_sda_en};
                end
            end
            if (done_at >= 0 && n >= done_at + 3) break;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int da, ea, nd, d1, d2, bad, early;
        logic [4:0] snap;
        logic exp_scl;

        set_vec(0, 16'hA55A, 8'h00, 0, 116, -1, 1'b0, 25, {8'hA0, 16'hA55A, 1'b0}, 3);
`ifdef I2C_SEQ_RETRY_EN
        set_vec(1, 16'h1234, 8'h01, 0, 160, -1, 1'b0, 34, {8'hA0, 1'b0, 8'hA0, 16'h1234, 1'b0}, 4);
`else
        set_vec(1, 16'h1234, 8'h01, 0, 44, 39, 1'b1, 9, {8'hA0, 1'b0}, 1);
`endif
        set_vec(2, 16'hBEEF, 8'h02, 0, 80, 75, 1'b1, 17, {8'hA0, 8'hBE, 1'b0}, 2);
        set_vec(3, 16'h0F0F, 8'h04, 0, 116, 111, 1'b1, 25, {8'hA0, 16'h0F0F, 1'b0}, 3);
        set_vec(4, 16'hFFFF, 8'h00, 0, 116, -1, 1'b0, 25, {8'hA0, 16'hFFFF, 1'b0}, 3);
        set_vec(5, 16'h0000, 8'h00, 0, 116, -1, 1'b0, 25, {8'hA0, 16'h0000, 1'b0}, 3);
        set_vec(6, 16'hA55A, 8'h00, 50, 116, -1, 1'b0, 25, {8'hA0, 16'hA55A, 1'b0}, 3);
`ifdef I2C_SEQ_RETRY_EN
        set_vec(7, 16'hC3C3, 8'h03, 0, 204, -1, 1'b0, 43,
                {8'hA0, 1'b0, 8'hA0, 1'b0, 8'hA0, 16'hC3C3, 1'b0}, 5);
        set_vec(8, 16'h5A5A, 8'h07, 0, 132, 127, 1'b1, 27,
                {8'hA0, 1'b0, 8'hA0, 1'b0, 8'hA0, 1'b0}, 3);
`else
        set_vec(7, 16'hC3C3, 8'h03, 0, 44, 39, 1'b1, 9, {8'hA0, 1'b0}, 1);
        set_vec(8, 16'h5A5A, 8'h07, 0, 44, 39, 1'b1, 9, {8'hA0, 1'b0}, 1);
`endif

        rst = 1'b1;
        bus1.i_start = 1'b0; bus1.i_data = 16'h0;
        bus3.i_start = 1'b0; bus3.i_data = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs_d1", {57'd0, bus1.o_busy, bus1.o_done, bus1.o_ack_err, bus1.o_scl, bus1.o_sda,
                              bus1.o_scl_en, bus1.o_sda_en}, 64'b0001100);
        chk("reset_data_d1", {48'd0, bus1.o_data}, 64'd0);
        chk("reset_outs_d3", {57'd0, bus3.o_busy, bus3.o_done, bus3.o_ack_err, bus3.o_scl, bus3.o_sda,
                              bus3.o_scl_en, bus3.o_sda_en}, 64'b0001100);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_outs_d1", {57'd0, bus1.o_busy, bus1.o_done, bus1.o_ack_err, bus1.o_scl, bus1.o_sda,
                             bus1.o_scl_en, bus1.o_sda_en}, 64'b0001100);

        for (int i = 0; i < NV; i++) begin
            run_txn(vecs[i].data, vecs[i].mask, vecs[i].inj, da, ea, nd, snap);
            chk($sformatf("v%0d_done_at", i), 64'(da), 64'(vecs[i].exp_done));
            chk($sformatf("v%0d_err_at", i), 64'(ea), 64'(vecs[i].exp_err_at));
            chk($sformatf("v%0d_ack_err", i), {63'd0, bus1.o_ack_err}, {63'd0, vecs[i].exp_err});
            chk($sformatf("v%0d_data_held", i), {48'd0, bus1.o_data}, {48'd0, vecs[i].data});
            chk($sformatf("v%0d_nbits", i), 64'(mon_nbits), 64'(vecs[i].exp_nbits));
            chk($sformatf("v%0d_bits", i), mon_bits, vecs[i].exp_bits);
            chk($sformatf("v%0d_ack_slots", i), 64'(mon_acks), 64'(vecs[i].exp_acks));
            chk($sformatf("v%0d_ndone", i), 64'(nd), 64'd1);
            chk($sformatf("v%0d_done_outs", i), {59'd0, snap}, 64'b01100);
        end

        // Held i_start: DONE ignores it, next accept is in the following IDLE cycle.
        @(posedge clk); #1;
        clr = 1'b1; mask_cur = 8'h00; bus1.i_data = 16'hA55A; bus1.i_start = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        d1 = -1; d2 = -1;
        for (int n = 1; n <= 600; n++) begin
            @(posedge clk); #1;
            if (bus1.o_done) begin
                if (d1 < 0) d1 = n;
                else begin
                    d2 = n; bus1.i_start = 1'b0; break;
                end
            end
        end
        bus1.i_start = 1'b0;
        chk("b2b_first_done", 64'(d1), 64'd116);
        chk("b2b_second_done", 64'(d2), 64'd234);
        repeat (3) @(posedge clk);
        #1;
        chk("b2b_no_third", {63'd0, bus1.o_busy}, 64'd0);

        // Reset during BYTE_LO.
        @(posedge clk); #1;
        clr = 1'b1; mask_cur = 8'h00; bus1.i_data = 16'hA55A; bus1.i_start = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0; bus1.i_start = 1'b0;
        repeat (79) @(posedge clk);
        #1;
        chk("pre_reset_busy_en", {62'd0, bus1.o_busy, bus1.o_sda_en}, 64'b11);
        rst = 1'b1;
        #1;
        chk("midop_reset_outs", {57'd0, bus1.o_busy, bus1.o_done, bus1.o_ack_err, bus1.o_scl, bus1.o_sda,
                                 bus1.o_scl_en, bus1.o_sda_en}, 64'b0001100);
        chk("midop_reset_data", {48'd0, bus1.o_data}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_txn(16'hA55A, 8'h00, 0, da, ea, nd, snap);
        chk("post_reset_done_at", 64'(da), 64'd116);
        chk("post_reset_bits", mon_bits, {39'd0, 8'hA0, 16'hA55A, 1'b0});

        // CLK_DIV=3: each quarter is 3 cycles, so SCL low/high last 6 cycles per bit.
        @(posedge clk); #1;
        bus3.i_data = 16'hA55A; bus3.i_start = 1'b1;
        @(posedge clk); #1;
        bus3.i_start = 1'b0;
        bad = 0; early = 0;
        for (int n = 0; n < 348; n++) begin
            if (n < 12) exp_scl = 1'b1;
            else exp_scl = ((n % 12) >= 6);
            if (bus3.o_scl !== exp_scl) bad++;
            if (bus3.o_done) early++;
            @(posedge clk); #1;
        end
        chk("d3_scl_shape", 64'(bad), 64'd0);
        chk("d3_no_early_done", 64'(early), 64'd0);
        chk("d3_done_at_348", {63'd0, bus3.o_done}, 64'd1);
        chk("d3_data", {48'd0, bus3.o_data}, 64'hA55A);
        chk("d3_ack_err", {63'd0, bus3.o_ack_err}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_write_sequencer.md
# i2c_write_sequencer

Single-master I2C write sequencer that turns a 16-bit payload into a complete bus transaction: START, 7-bit address + W, two data bytes with ACK checks, and STOP. It drives the SCL/SDA lines and their enables into the bus pad logic. It also presents the transmitted word on `o_data` so the existing bus monitor can split it into its two bytes for comparison.

## Interface
- `CLK_DIV`, 4: `i_clk` cycles per SCL quarter-period; legal range 1..255.
- `ADDR`, 7'h50: 7-bit target address; the R/W bit is always 0.

- `i_clk`, in, 1: single clock; all logic on the rising edge.
- `i_rst`, in, 1: reset, asynchronous and active-high.
- `i_start`, in, 1: transaction request; sampled only in IDLE.
- `i_data`, in, 16: payload; `[15:8]` is sent first, `[7:0]` second, each MSB first.
- `i_sda`, in, 1: sampled bus SDA, used for the ACK bits.
- `o_busy`, out, 1: high from transaction accept until DONE.
- `o_done`, out, 1: one-cycle completion pulse.
- `o_ack_err`, out, 1: NACK seen in the last transaction; held until the next accept.
- `o_data`, out, 16: payload latched at accept; held until the next accept.
- `o_scl`, out, 1: SCL drive value.
- `o_sda`, out, 1: SDA drive value.
- `o_scl_en`, out, 1: SCL output enable.
- `o_sda_en`, out, 1: SDA output enable.

## Operation
- **States:** IDLE → START → ADDR → ACK_A → BYTE_HI → ACK_H → BYTE_LO → ACK_L → STOP → DONE → IDLE.
- **Quarter timing:** every non-IDLE/DONE bit slot is 4 quarters (q0..q3), each lasting CLK_DIV cycles; an 8-bit quarter counter runs alongside a 2-bit phase counter and a 3-bit bit index.
- **Data bit:**
  - q0, q1: SCL=0. SDA is updated at the start of q0.
  - q2, q3: SCL=1.
- **START:**
  - q0, q1: SCL=1, SDA=1.
  - q2, q3: SCL=1, SDA=0.
- **STOP:**
  - q0, q1: SCL=0, SDA=0.
  - q2: SCL=1, SDA=0.
  - q3: SCL=1, SDA=1.
- **ACK slot:**
  - `o_sda_en`=0 for all 4 quarters; SCL follows the data-bit pattern.
  - `i_sda` is sampled on the first cycle of q2.
  - 0 = ACK: continue to the next state.
  - 1 = NACK: set `o_ack_err` and go to STOP.
- **Address byte:** `{ADDR,1'b0}`, MSB first.
- **Accept:** in IDLE with `i_start`=1:
  - latch `i_data` into `o_data`;
  - clear `o_ack_err`;
  - set `o_busy`;
  - assert `o_scl_en`=1 and `o_sda_en`=1.
- **Enables while busy:** `o_scl_en`=1 throughout the transaction; `o_sda_en`=1 except in ACK slots.
- **DONE:** lasts one cycle. `o_done`=1, `o_busy`=0, both enables 0, `o_scl`=`o_sda`=1.
- **Ignored requests:** `i_start` in any state other than IDLE, including DONE, is ignored; it is not queued.
- **Reset values:**
  - `o_busy`=0, `o_done`=0, `o_ack_err`=0, `o_data`=0;
  - `o_scl`=1, `o_sda`=1;
  - `o_scl_en`=0, `o_sda_en`=0;
  - state IDLE, all counters 0.
- **Reset mid-transaction:** immediate return to the reset values; the bus is released with no STOP generated.

## Timing
- **Accept:** `i_start` is sampled high in IDLE at edge k.
  - From edge k: `o_busy`=1 and START q0 begins.
- **Full transaction:** START 4 quarters + 27 bit slots × 4 quarters + STOP 4 quarters = 116 quarters.
  - `o_done` is high for the cycle following the last STOP quarter: k + 116·CLK_DIV.
- **Address NACK:** 4 + 9×4 + 4 = 44 quarters; `o_done` at k + 44·CLK_DIV.
- **High-byte NACK:** 80 quarters.
- **Flag timing:**
  - `o_ack_err` rises on the cycle after the q2 sample edge.
  - `o_data` changes only at accept.
- **Back-to-back:** the earliest next accept is the IDLE cycle after DONE, so there are at least 2 cycles between `o_done` pulses plus the transaction length.

## Configuration
- **`I2C_SEQ_RETRY_EN` defined:**
  - An address NACK does not end the transaction; after STOP, the sequencer re-enters START automatically.
  - Up to 3 attempts in total; `o_busy` stays high and no `o_done` is issued between attempts.
  - `o_ack_err` is set only if the third attempt is NACKed.
  - Data-byte NACKs still abort with no retry.
- **Undefined:** single attempt; any NACK sets `o_ack_err` and goes to STOP.

## Test plan
- **Clean write:** CLK_DIV=1, ADDR=7'h50, `i_data`=16'hA55A, `i_sda`=0 in ACK slots.
  - SDA bytes sampled at SCL rise: 8'hA0, 8'hA5, 8'h5A.
  - `o_done` at k+116; `o_ack_err`=0; `o_data`=16'hA55A.
- **Address NACK (macro off):** `i_sda`=1 in ACK_A.
  - `o_ack_err`=1 and STOP issued.
  - `o_done` at k+44; no data bits driven.
- **Address NACK (macro on):**
  - NACK on attempts 1–2 then ACK on attempt 3: `o_done` at k+44+44+116, `o_ack_err`=0.
  - NACK on all three attempts: `o_done` at k+132, `o_ack_err`=1.
- **Busy lockout:** pulse `i_start` with `i_data`=16'h1234 during BYTE_HI of a 16'hA55A transfer.
  - Ignored: `o_data` stays 16'hA55A and exactly one `o_done`.
- **Reset mid-op:** assert `i_rst` during BYTE_LO.
  - Same cycle: enables 0, `o_scl`=`o_sda`=1, `o_busy`=0.
  - After release, a new `i_start` yields a full 116-quarter transaction.
- **Divider check:** CLK_DIV=3.
  - SCL high and low each last 6 cycles per bit.
  - `o_done` at k+348.
